// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared constants and types for the iterative shift-add multiplier.
//   MULT_WIDTH : default operand width in bits
//   PROD_W     : product width at the default operand width
//   state_t    : controller state encoding (IDLE / RUN / DONE)
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_WIDTH = 12;
  localparam int PROD_W     = 2 * MULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
// One combinational add-and-shift step of a shift-add multiplier.
// Ports:
//   acc         in   WIDTH  upper half of the running {acc,mplier} register
//   mcand       in   WIDTH  multiplicand
//   mplier      in   WIDTH  lower half; bit 0 selects whether mcand is added
//   acc_next    out  WIDTH  upper half after the step
//   mplier_next out  WIDTH  lower half after the step
// ---------------------------------------------------------------------------
module mult_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mplier_next
);

  logic [WIDTH:0] sum;

  // The add keeps its carry in bit WIDTH. Shifting {sum,mplier} right by one
  // drops the multiplier bit just consumed and moves the sum's low bit into
  // the top of the multiplier half, so the carry lands back inside acc.
  always_comb begin
    sum         = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next    = sum[WIDTH:1];
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_core.sv
// ---------------------------------------------------------------------------
// mult_core
// Iterative unsigned shift-add multiplier, z = x * y, one bit per clock.
// The product is handed to a downstream serialiser only when it is not busy.
// Ports:
//   clk         in   1        system clock, rising edge
//   reset       in   1        synchronous active-high reset
//   start       in   1        begin a multiply (sampled only while idle)
//   x_parallel  in   WIDTH    multiplicand, captured on the accepting edge
//   y_parallel  in   WIDTH    multiplier, captured on the accepting edge
//   z_busy      in   1        downstream busy; holds the product hand-off
//   busy        out  1        high whenever a multiply is in progress
//   z_parallel  out  2*WIDTH  product register, updated on hand-off only
//   sz          out  1        one-cycle strobe following a z_parallel update
// ---------------------------------------------------------------------------
module mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   x_parallel,
  input  logic [WIDTH-1:0]   y_parallel,
  input  logic               z_busy,
  output logic               busy,
  output logic [2*WIDTH-1:0] z_parallel,
  output logic               sz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mplier_next (mplier_next)
  );

  // State register for the IDLE -> RUN -> DONE controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN lasts exactly WIDTH steps; DONE waits for the
  // downstream to become free before returning to IDLE. start outside IDLE
  // is deliberately ignored rather than queued.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start)              state_d = RUN;
      RUN:     if (count == LAST_STEP) state_d = DONE;
      DONE:    if (!z_busy)            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one add-shift per RUN cycle, and the
  // product hand-off in DONE. sz defaults low so it can only ever last a
  // single cycle, and a reset mid-multiply leaves nothing to hand off.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      z_parallel <= '0;
      sz         <= 1'b0;
    end else begin
      sz <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= x_parallel;
            mplier <= y_parallel;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          count  <= count + 1'b1;
        end
        DONE: begin
          if (!z_busy) begin
            z_parallel <= {acc, mplier};
            sz         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_core.md
Name: mult_core

Overview:
- Iterative shift-add unsigned multiplier. Computes z = x * y for two WIDTH-bit operands and hands the 2*WIDTH-bit product to shift_out.
- Sits directly upstream of shift_out:
  - z_parallel drives shift_out.z_parallel.
  - sz drives shift_out.sz.
  - shift_out.fz feeds back as z_busy, so a new product is never presented while a serial transfer is in flight.

Parameters:
WIDTH, 12, operand width in bits; product width is 2*WIDTH (24 at default, matching shift_out).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
start  input  1  level; sampled only in IDLE; high begins a multiply using x_parallel/y_parallel.
x_parallel  input  WIDTH  multiplicand; captured on the accepting edge.
y_parallel  input  WIDTH  multiplier; captured on the accepting edge.
z_busy  input  1  downstream busy (shift_out.fz); high blocks product hand-off.
busy  output  1  high whenever state != IDLE.
z_parallel  output  2*WIDTH  product register; changes only on the hand-off edge.
sz  output  1  registered one-cycle strobe; high for exactly the cycle after z_parallel updates.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, count=0, internal acc/mcand/mplier=0, z_parallel=0, sz=0, busy=0. Reset mid-operation aborts the multiply and no sz is issued. Reset overrides all other inputs on the same edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: mcand<=x_parallel, mplier<=y_parallel, acc<=0, count<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN, one step per edge:
  - Sum = {1'b0,acc} + (mplier[0] ? mcand : 0), WIDTH+1 bits; the carry is kept.
  - {acc,mplier} <= {sum,mplier} >> 1, a 2*WIDTH+1-bit right shift that drops the old mplier[0].
  - count<=count+1.
  - On the edge where count==WIDTH-1 (edge k+WIDTH), state<=DONE.
- count width: clog2(WIDTH)+1 bits. count never wraps; it is reset on every accept.
- DONE:
  - Product = {acc,mplier}, 2*WIDTH bits, exact; there is no overflow by construction.
  - If z_busy=0: z_parallel<=product, sz<=1, state<=IDLE.
  - If z_busy=1: hold in DONE with z_parallel unchanged and sz=0. There is no timeout.
- sz is cleared on the edge after it is set, regardless of state.
- Latency, z_busy=0 throughout:
  - start accepted at edge k; sz set at edge k+WIDTH+1 and cleared at k+WIDTH+2. At default WIDTH this is 13 edges.
  - With start held high continuously, the next op is accepted at edge k+WIDTH+2, giving a throughput of 1 op per WIDTH+2 cycles.
- start in RUN or DONE is ignored; it is not queued. Operand inputs are don't-care except on the accepting edge.
- z_busy is sampled only in DONE. z_busy rising during RUN has no effect until DONE is reached.
- sz low→high timing: sz is always low for at least WIDTH+1 cycles between strobes, which satisfies shift_out's low-then-high start detection.

Decomposition:
- Package mult_pkg holds:
  - WIDTH default constant (12).
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - PROD_W = 2*WIDTH.
- One sub-module is natural: mult_step. It is a combinational add-and-shift of {acc,mplier} by one step, reusable by a later radix-4 variant.
- The FSM, counter and output registers remain in mult_core.

Test Plan:
- Reset then idle 20 cycles with start=0 -> busy=0, sz=0, z_parallel=24'h000000 throughout.
- x=12'd3, y=12'd5, start pulse at edge k, z_busy=0 -> busy high from k; z_parallel=24'h00000F and sz=1 after edge k+13; sz=0 after k+14.
- x=12'hFFF, y=12'hFFF -> z_parallel=24'hFFE001. Then x=12'h000, y=12'hABC -> 24'h000000. Then x=12'h800, y=12'h002 -> 24'h001000.
- x=12'd100, y=12'd200 with z_busy=1 from k to k+30 -> state holds DONE, sz=0, z_parallel keeps its prior value. z_busy drops at k+30 -> z_parallel=24'h004E20 and sz=1 after the next edge.
- start re-asserted at k+4 with x=12'd7, y=12'd7 during the op x=12'd9, y=12'd9 -> only 24'h000051 is produced; no second sz.
- reset asserted at k+6 mid-RUN for 1 cycle -> after that edge busy=0, sz=0, z_parallel=0; no sz in the following 20 cycles. A new start then completes normally.
